// File: rtl/chr_scan_if.sv
// Scanner-side bundle: VRAM read port plus the pixel-aligned character stream
// handed to the font/pixel stage.
interface chr_scan_if #(
  parameter int unsigned DAT_W = 8,
  parameter int unsigned ADR_W = 10
);
  logic [ADR_W-1:0] ras;
  logic [DAT_W-1:0] rds;
  logic [DAT_W-1:0] chr;
  logic [2:0]       chr_x;
  logic [2:0]       chr_y;
  logic             de;
  logic             xhs;
  logic             xvs;
  logic             frm;

  modport master (
    output ras, chr, chr_x, chr_y, de, xhs, xvs, frm,
    input  rds
  );

  modport slave (
    input  ras, chr, chr_x, chr_y, de, xhs, xvs, frm,
    output rds
  );
endinterface

// File: rtl/chr_scan.sv
// Raster scanner for the character generator: H/V timing, incremental VRAM
// addressing and a 4-stage sideband delay line aligned with the RAM read.
module chr_scan #(
  parameter int unsigned C_DAT_W   = 8,
  parameter int unsigned C_ADR_W   = 10,
  parameter int unsigned C_COLS    = 32,
  parameter int unsigned C_ROWS    = 30,
  parameter int unsigned C_H_TOTAL = 341,
  parameter int unsigned C_V_TOTAL = 262,
  parameter int unsigned C_HS_BGN  = 280,
  parameter int unsigned C_HS_W    = 25,
  parameter int unsigned C_VS_BGN  = 245,
  parameter int unsigned C_VS_W    = 3
) (
  input  logic       CK_i,
  input  logic       AR_i,
  chr_scan_if.master bus
);

  localparam int unsigned H_W = $clog2(C_H_TOTAL);
  localparam int unsigned V_W = $clog2(C_V_TOTAL);
  localparam logic [H_W-1:0] H_LAST = H_W'(C_H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(C_V_TOTAL - 1);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       frm;
    logic [2:0] x;
    logic [2:0] y;
  } side_t;

  logic [H_W-1:0]     h;
  logic [V_W-1:0]     v;
  logic [C_ADR_W-1:0] row_base;
  logic [C_ADR_W-1:0] ras;
  logic [C_DAT_W-1:0] chr;
  logic               line_end;
  logic               frame_end;
  side_t              dec;
  side_t              pipe [4];

  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  always_comb begin
    dec     = '0;
    dec.act = (32'(h) < C_COLS * 8) && (32'(v) < C_ROWS * 8);
    dec.hs  = (32'(h) >= C_HS_BGN) && (32'(h) < C_HS_BGN + C_HS_W);
    dec.vs  = (32'(v) >= C_VS_BGN) && (32'(v) < C_VS_BGN + C_VS_W);
    dec.frm = (h == '0) && (v == '0);
    dec.x   = h[2:0];
    dec.y   = v[2:0];
  end

  // Row base tracks (v>>3)*C_COLS; it stops advancing after the last text row
  // so it never leaves the text area during vertical blanking.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (frame_end) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= v + V_W'(1);
      if ((v[2:0] == 3'd7) && (32'(v) < C_ROWS * 8 - 1))
        row_base <= row_base + C_ADR_W'(C_COLS);
    end else begin
      h <= h + H_W'(1);
    end
  end

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i)
      ras <= '0;
    else if (dec.act)
      ras <= row_base + C_ADR_W'(h[H_W-1:3]);
  end

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      for (int unsigned i = 0; i < 4; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= dec;
      for (int unsigned i = 1; i < 4; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // Stage 2 of the delay line lines up with the RAM data for the same pixel.
  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i)
      chr <= '0;
    else
      chr <= pipe[2].act ? bus.rds : '0;
  end

  assign bus.ras   = ras;
  assign bus.chr   = chr;
  assign bus.chr_x = pipe[3].x;
  assign bus.chr_y = pipe[3].y;
  assign bus.de    = pipe[3].act;
  assign bus.xhs   = ~pipe[3].hs;
  assign bus.xvs   = ~pipe[3].vs;
  assign bus.frm   = pipe[3].frm;

endmodule

// File: tb/tb_chr_scan.sv
// Bench for chr_scan: default-timing scanner plus a miniature one for frame
// wrap and frame-period checks, both against a pixel-index model.
module tb_chr_scan;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;

  localparam int D_COLS = 32, D_ROWS = 30, D_HT = 341, D_VT = 262;
  localparam int D_HSB = 280, D_HSW = 25, D_VSB = 245, D_VSW = 3;
  localparam int S_COLS = 4, S_ROWS = 3, S_HT = 45, S_VT = 30;
  localparam int S_HSB = 36, S_HSW = 4, S_VSB = 26, S_VSW = 2;

  typedef struct packed {
    logic [AW-1:0] ras;
    logic [DW-1:0] chr;
    logic [2:0]    x;
    logic [2:0]    y;
    logic          de;
    logic          xhs;
    logic          xvs;
    logic          frm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   mode0, mode1;
  int   k0, k1;
  int   total = 0;
  int   passed = 0;
  int   last_frm1 = 0;

  chr_scan_if #(.DAT_W(DW), .ADR_W(AW)) bus0 ();
  chr_scan_if #(.DAT_W(DW), .ADR_W(AW)) bus1 ();

  chr_scan #(
    .C_DAT_W(DW), .C_ADR_W(AW), .C_COLS(D_COLS), .C_ROWS(D_ROWS),
    .C_H_TOTAL(D_HT), .C_V_TOTAL(D_VT), .C_HS_BGN(D_HSB), .C_HS_W(D_HSW),
    .C_VS_BGN(D_VSB), .C_VS_W(D_VSW)
  ) dut0 (.CK_i(clk), .AR_i(rst0), .bus(bus0));

  chr_scan #(
    .C_DAT_W(DW), .C_ADR_W(AW), .C_COLS(S_COLS), .C_ROWS(S_ROWS),
    .C_H_TOTAL(S_HT), .C_V_TOTAL(S_VT), .C_HS_BGN(S_HSB), .C_HS_W(S_HSW),
    .C_VS_BGN(S_VSB), .C_VS_W(S_VSW)
  ) dut1 (.CK_i(clk), .AR_i(rst1), .bus(bus1));

  // RAM contents per mode: 0 = low byte of address, 1 = 0xA5 only at 5, 2 = all 0xFF
  function automatic logic [DW-1:0] ram_f(input int m, input int a);
    case (m)
      0:       return DW'(a & 255);
      1:       return (a == 5) ? DW'(8'hA5) : '0;
      default: return DW'(8'hFF);
    endcase
  endfunction

  // Two-cycle read latency from the address register to the data port
  logic [AW-1:0] q0a, q0b, q1a, q1b;
  always @(posedge clk) begin
    q0a <= bus0.ras;
    q0b <= q0a;
    q1a <= bus1.ras;
    q1b <= q1a;
  end
  assign bus0.rds = ram_f(mode0, int'(q0b));
  assign bus1.rds = ram_f(mode1, int'(q1b));

  always @(posedge clk or posedge rst0)
    if (rst0) k0 <= 0; else k0 <= k0 + 1;
  always @(posedge clk or posedge rst1)
    if (rst1) k1 <= 0; else k1 <= k1 + 1;

  // Expected outputs after k edges since reset release, from pixel index arithmetic
  function automatic exp_t model(input int i, input int k);
    exp_t e;
    int cols, rows, ht, vt, hsb, hsw, vsb, vsw, m, p, h, v, a;
    if (i == 0) begin
      cols = D_COLS; rows = D_ROWS; ht = D_HT; vt = D_VT;
      hsb = D_HSB; hsw = D_HSW; vsb = D_VSB; vsw = D_VSW; m = mode0;
    end else begin
      cols = S_COLS; rows = S_ROWS; ht = S_HT; vt = S_VT;
      hsb = S_HSB; hsw = S_HSW; vsb = S_VSB; vsw = S_VSW; m = mode1;
    end
    e = '0;
    e.xhs = 1'b1;
    e.xvs = 1'b1;
    if (k >= 1) begin
      p = k - 1;
      h = p % ht;
      v = (p / ht) % vt;
      if (v >= rows * 8)      a = cols * rows - 1;
      else if (h >= cols * 8) a = (v / 8) * cols + cols - 1;
      else                    a = (v / 8) * cols + h / 8;
      e.ras = AW'(a);
    end
    if (k >= 4) begin
      p = k - 4;
      h = p % ht;
      v = (p / ht) % vt;
      e.de  = (h < cols * 8) && (v < rows * 8);
      e.x   = 3'(h % 8);
      e.y   = 3'(v % 8);
      e.xhs = !((h >= hsb) && (h < hsb + hsw));
      e.xvs = !((v >= vsb) && (v < vsb + vsw));
      e.frm = (h == 0) && (v == 0);
      e.chr = e.de ? ram_f(m, (v / 8) * cols + h / 8) : '0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int i, input int k, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s dut%0d k=%0d got=%0h want=%0h", name, i, k, got, want);
  endtask

  task automatic check_dut(input int i, input logic r, input int k,
                           input logic [AW-1:0] ras, input logic [DW-1:0] chr,
                           input logic [2:0] x, input logic [2:0] y, input logic de,
                           input logic xhs, input logic xvs, input logic frm);
    exp_t e;
    int kk;
    kk = r ? 0 : k;
    e = model(i, kk);
    chk("ras", i, kk, int'(ras), int'(e.ras));
    chk("chr", i, kk, int'(chr), int'(e.chr));
    chk("chr_x", i, kk, int'(x), int'(e.x));
    chk("chr_y", i, kk, int'(y), int'(e.y));
    chk("de", i, kk, int'(de), int'(e.de));
    chk("xhs", i, kk, int'(xhs), int'(e.xhs));
    chk("xvs", i, kk, int'(xvs), int'(e.xvs));
    chk("frm", i, kk, int'(frm), int'(e.frm));
  endtask

  always @(negedge clk) begin
    check_dut(0, rst0, k0, bus0.ras, bus0.chr, bus0.chr_x, bus0.chr_y,
              bus0.de, bus0.xhs, bus0.xvs, bus0.frm);
    check_dut(1, rst1, k1, bus1.ras, bus1.chr, bus1.chr_x, bus1.chr_y,
              bus1.de, bus1.xhs, bus1.xvs, bus1.frm);

    // Hand-computed pins for the model
    if (!rst0 && k0 == 4)                 chk("lit_frm_first", 0, k0, int'(bus0.frm), 1);
    if (!rst0 && k0 == 3)                 chk("lit_frm_early", 0, k0, int'(bus0.frm), 0);
    if (!rst0 && mode0 == 0 && k0 == 12)  chk("lit_chr_h8", 0, k0, int'(bus0.chr), 1);
    if (!rst0 && mode0 == 0 && k0 == 259) chk("lit_chr_last_col", 0, k0, int'(bus0.chr), 31);
    if (!rst0 && mode0 == 0 && k0 == 260) chk("lit_de_h256", 0, k0, int'(bus0.de), 0);
    if (!rst0 && mode0 == 0 && k0 == 2732) chk("lit_chr_line8", 0, k0, int'(bus0.chr), 32);
    if (!rst0 && mode0 == 0 && k0 == 283) chk("lit_xhs_279", 0, k0, int'(bus0.xhs), 1);
    if (!rst0 && mode0 == 0 && k0 == 284) chk("lit_xhs_280", 0, k0, int'(bus0.xhs), 0);
    if (!rst0 && mode0 == 0 && k0 == 308) chk("lit_xhs_304", 0, k0, int'(bus0.xhs), 0);
    if (!rst0 && mode0 == 0 && k0 == 309) chk("lit_xhs_305", 0, k0, int'(bus0.xhs), 1);
    if (!rst0 && mode0 == 1 && k0 == 44)  chk("lit_a5_h40", 0, k0, int'(bus0.chr), 'hA5);
    if (!rst0 && mode0 == 1 && k0 == 52)  chk("lit_a5_h48", 0, k0, int'(bus0.chr), 0);
    if (!rst0 && mode0 == 2 && k0 == 104) chk("lit_ff_active", 0, k0, int'(bus0.chr), 'hFF);
    if (!rst0 && mode0 == 2 && k0 == 260) chk("lit_ff_blank", 0, k0, int'(bus0.chr), 0);
    if (!rst1 && mode1 == 0 && k1 == 1070) chk("lit_small_last", 1, k1, int'(bus1.chr), 11);
    if (!rst1 && mode1 == 0 && k1 >= 1 && ((k1 - 1) % (S_HT * S_VT)) == 0)
      chk("lit_ras_frame_start", 1, k1, int'(bus1.ras), 0);

    if (rst1) begin
      last_frm1 = 0;
    end else if (bus1.frm) begin
      if (last_frm1 > 0) chk("frm_period", 1, k1, k1 - last_frm1, S_HT * S_VT);
      last_frm1 = k1;
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; mode0 = 0; mode1 = 0;
    repeat (10) @(posedge clk);
    #1 rst0 = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk);
    #1 rst0 = 1'b0;
    repeat (10 * D_HT + 20) @(posedge clk);
    #1 rst0 = 1'b1; mode0 = 1;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    repeat (9 * D_HT + 10) @(posedge clk);
    #1 rst0 = 1'b1; mode0 = 2;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    repeat (2 * D_HT) @(posedge clk);
    #1 rst0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    repeat (3 * S_HT * S_VT + 100) @(posedge clk);
    #1 rst1 = 1'b1; mode1 = 1;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    repeat (S_HT * S_VT + 50) @(posedge clk);
    #1 rst1 = 1'b1; mode1 = 2;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    repeat (S_HT * S_VT + 50) @(posedge clk);
    #1 rst1 = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
